// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, RV32I width codes and fault causes for the load/store unit
package lsu_pkg;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_BUSERR   = 2'b10;
   localparam logic [1:0] FC_TIMEOUT  = 2'b11;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: misalign detection, store lane replication/strobes and load extraction
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic        misalign_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);
   logic        is_b;
   logic        is_h;
   logic        sgn;
   logic [7:0]  b;
   logic [15:0] h;
   assign is_b = funct3_i == F3_B || funct3_i == F3_BU;
   assign is_h = funct3_i == F3_H || funct3_i == F3_HU;
   assign sgn  = funct3_i == F3_B || funct3_i == F3_H;
   assign b    = rdata_i[{off_i, 3'b000} +: 8];
   assign h    = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   // any code that is not a byte or half access behaves as a word access
   always_comb begin
      misalign_o = is_h ? off_i[0] : (!is_b && off_i != 2'b00);
      wstrb_o    = is_b ? 4'b0001 << off_i : is_h ? 4'b0011 << off_i : 4'b1111;
      wdata_o    = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
      rdata_o    = is_b ? {{24{sgn & b[7]}}, b} : is_h ? {{16{sgn & h[15]}}, h} : rdata_i;
   end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with stall, extension and fault reporting
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic        mem_err,
   input  logic [31:0] mem_rdata
);
   state_e      state_q, state_d;
   logic [29:0] waddr_q, waddr_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic        we_q, we_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  cause_q, cause_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        en;
   logic        idle;
   logic        mis;
   logic        mis_pulse;
   logic        timeout_hit;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   assign en          = mem_rd | mem_wr;
   assign idle        = state_q == S_IDLE;
   assign mis_pulse   = idle & en & mis;
   assign timeout_hit = cnt_q == 8'(TIMEOUT - 1);
   // in IDLE the aligner sees the live instruction, afterwards the captured one
   lsu_align u_align (
      .funct3_i   (idle ? funct3 : f3_q),
      .off_i      (idle ? addr[1:0] : off_q),
      .wdata_i    (wdata),
      .rdata_i    (mem_rdata),
      .misalign_o (mis),
      .wstrb_o    (al_wstrb),
      .wdata_o    (al_wdata),
      .rdata_o    (al_rdata)
   );
   // next-state and capture logic for the access FSM
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      off_d   = off_q;
      f3_d    = f3_q;
      we_d    = we_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (en && !mis) begin
            state_d = S_REQ;
            waddr_d = addr[31:2];
            off_d   = addr[1:0];
            f3_d    = funct3;
            we_d    = !mem_rd;
            wstrb_d = mem_rd ? 4'b0000 : al_wstrb;
            wdata_d = al_wdata;
         end
         S_REQ: if (mem_gnt) begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (mem_rvalid) begin
               state_d = S_DONE;
               cause_d = mem_err ? FC_BUSERR : FC_NONE;
               rdata_d = we_q ? rdata_q : mem_err ? 32'd0 : al_rdata;
            end else if (timeout_hit) begin
               state_d = S_DONE;
               cause_d = FC_TIMEOUT;
               rdata_d = we_q ? rdata_q : 32'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   // state and captured-access registers, abandoned asynchronously on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         waddr_q <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         wstrb_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cause_q <= FC_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end
   // core-side and bus-side outputs decoded from the state
   always_comb begin
      stall       = (idle & en & !mis) | state_q == S_REQ | state_q == S_WAIT;
      done        = state_q == S_DONE | mis_pulse;
      fault       = (state_q == S_DONE & cause_q != FC_NONE) | mis_pulse;
      fault_cause = state_q == S_DONE ? cause_q : mis_pulse ? FC_MISALIGN : FC_NONE;
      mem_req     = state_q == S_REQ;
      mem_we      = state_q == S_REQ & we_q;
      mem_addr    = {waddr_q, 2'b00};
      mem_wstrb   = wstrb_q;
      mem_wdata   = wdata_q;
      rdata       = rdata_q;
   end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a spec-level reference model
module tb_lsu;
   import lsu_pkg::*;
   localparam int TO = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_rd = 1'b0, mem_wr = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        stall, done, fault, mem_req, mem_we;
   logic [1:0]  fault_cause;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
   logic [31:0] mem_rdata = '0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_rdata = '0;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
      .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_err(mem_err), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_misalign(input logic [2:0] f, input logic [31:0] a);
      case (f)
         3'b000, 3'b100: return 1'b0;
         3'b001, 3'b101: return a[0];
         default:        return a[1:0] != 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] f, input logic [31:0] a);
      case (f)
         3'b000:  return 4'(1 << a[1:0]);
         3'b001:  return 4'(3 << a[1:0]);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
      case (f)
         3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
         3'b001:  return {d[15:0], d[15:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] bt, hw;
      bt = (w >> (8 * a[1:0])) & 32'hFF;
      hw = (w >> (16 * a[1])) & 32'hFFFF;
      case (f)
         3'b000:  return bt[7] ? bt - 32'h100 : bt;
         3'b100:  return bt;
         3'b001:  return hw[15] ? hw - 32'h10000 : hw;
         3'b101:  return hw;
         default: return w;
      endcase
   endfunction

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   // rvd < 0 means the bus never responds; stray raises rvalid in the idle cycle after
   task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd, input int gd, input int rvd,
                         input bit err, input logic [31:0] rw, input bit stray);
      int d, stalls, w0;
      logic [1:0] cause;
      mem_rd = rd; mem_wr = wr; funct3 = f; addr = a; wdata = wd;
      mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
      if (m_misalign(f, a)) begin
         @(negedge clk);
         chk({tag, "_mis"}, {done, fault, fault_cause, stall, mem_req}, {1'b1, 1'b1, FC_MISALIGN, 1'b0, 1'b0});
         nxt;
         mem_rd = 0; mem_wr = 0;
         @(negedge clk);
         chk({tag, "_mis_idle"}, {done, stall, mem_req}, 3'b000);
         nxt;
         return;
      end
      w0 = gd + 2;
      d = rvd < 0 ? w0 + TO : w0 + rvd + 1;
      cause = rvd < 0 ? FC_TIMEOUT : err ? FC_BUSERR : FC_NONE;
      if (rd) exp_rdata = cause == FC_NONE ? m_load(f, a, rw) : 32'd0;
      stalls = 0;
      for (int c = 0; c <= d; c++) begin
         mem_gnt = c == gd + 1;
         mem_rvalid = rvd >= 0 && c == w0 + rvd;
         mem_err = mem_rvalid ? err : 1'($urandom_range(0, 1));
         mem_rdata = mem_rvalid ? rw : $urandom;
         @(negedge clk);
         stalls += int'(stall);
         chk($sformatf("%s_ctl%0d", tag, c), {stall, done, mem_req}, {c < d, c == d, c >= 1 && c <= gd + 1});
         if (c >= 1 && c <= gd + 1) begin
            chk({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
            chk({tag, "_we"}, mem_we, !rd);
            if (!rd) begin
               chk({tag, "_strb"}, mem_wstrb, m_strb(f, a));
               chk({tag, "_wdata"}, mem_wdata, m_wdata(f, wd));
            end
         end
         if (c == d) begin
            chk({tag, "_fault"}, {fault, fault_cause}, {cause != FC_NONE, cause});
            chk({tag, "_rdata"}, rdata, exp_rdata);
         end
         nxt;
      end
      chk({tag, "_stalls"}, stalls, d);
      mem_rd = 0; mem_wr = 0; mem_gnt = 0; mem_rvalid = stray; mem_err = 0;
      @(negedge clk);
      chk({tag, "_after"}, {stall, done, mem_req, fault}, 4'b0000);
      chk({tag, "_hold"}, rdata, exp_rdata);
      nxt;
      mem_rvalid = 0;
   endtask

   initial begin
      #12;
      chk("reset_ctl", {stall, done, fault, fault_cause, mem_req, mem_we, mem_wstrb}, '0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_addr", mem_addr, 32'd0);
      chk("reset_wdata", mem_wdata, 32'd0);
      nxt;
      rst_n = 1;
      nxt;
      access("lb", 1, 0, F3_B, 32'h0000_1003, 32'd0, 0, 0, 0, 32'h80FF_FF7F, 0);
      chk("lb_value", exp_rdata, 32'hFFFF_FF80);
      access("sh", 0, 1, F3_H, 32'h0000_2002, 32'h1234_ABCD, 3, 0, 0, 32'd0, 0);
      access("lw_mis", 1, 0, F3_W, 32'h0000_3001, 32'd0, 0, 0, 0, 32'd0, 0);
      access("lhu_err", 1, 0, F3_HU, 32'h0000_4002, 32'd0, 0, 1, 1, 32'h8001_0000, 0);
      access("lhu_ok", 1, 0, F3_HU, 32'h0000_4002, 32'd0, 1, 0, 0, 32'h8001_0000, 0);
      chk("lhu_value", exp_rdata, 32'h0000_8001);
      access("timeout", 1, 0, F3_W, 32'h0000_5000, 32'd0, 0, -1, 0, 32'hDEAD_BEEF, 1);
      access("last_ok", 1, 0, F3_W, 32'h0000_5004, 32'd0, 0, TO - 1, 0, 32'h0BAD_F00D, 0);
      // reset while waiting for a response
      mem_rd = 1; funct3 = F3_W; addr = 32'h0000_6000; mem_gnt = 0; mem_rvalid = 0;
      nxt;
      mem_gnt = 1;
      nxt;
      mem_gnt = 0;
      #2;
      chk("pre_rst_stall", {stall, mem_req}, 2'b10);
      rst_n = 0;
      #1;
      chk("rst_async", {mem_req, done}, 2'b00);
      mem_rd = 0;
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_rdata", rdata, 32'd0);
      exp_rdata = 32'd0;
      nxt;
      rst_n = 1;
      @(negedge clk);
      chk("rst_idle", {stall, mem_req, done}, 3'b000);
      nxt;
      access("post_rst", 1, 0, F3_BU, 32'h0000_7001, 32'd0, 0, 0, 0, 32'h0000_9A00, 0);
      for (int i = 0; i < 60; i++) begin
         int op, gd, rvd;
         logic [2:0] f;
         op = $urandom_range(0, 2);
         f = op == 1 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         gd = $urandom_range(0, 3);
         rvd = $urandom_range(0, 9) == 0 ? -1 : $urandom_range(0, TO - 1);
         access($sformatf("rnd%0d", i), op != 1, op != 0, f, $urandom, $urandom, gd, rvd,
                $urandom_range(0, 7) == 0, $urandom, 1'($urandom_range(0, 1)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
